// File: rtl/mux_masters_pkg.sv
// Shared types and helpers for the round-robin N-master to 1-slave bus mux.
package mux_masters_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Index/counter width that never collapses to zero bits.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_masters_rr_if.sv
// Bus bundle between N master cores, the mux, and the single shared slave.
interface mux_masters_rr_if
  import mux_masters_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int ID_W = width_of(MASTERS);

  // Handshake: a master holds req (with addr/cmd/wdata stable) until it sees
  // its one-cycle ack; err coincides with ack on timeout; rdata is valid only
  // in the acked lane. The slave completes with a one-cycle slave_ack while
  // slave_req is high; slave_rdata is valid with slave_ack.
  logic [MASTERS-1:0]        master_req;
  logic [MASTERS*ADDR_W-1:0] master_addr;
  logic [MASTERS-1:0]        master_cmd;
  logic [MASTERS*DATA_W-1:0] master_wdata;
  logic [MASTERS-1:0]        master_ack;
  logic [MASTERS-1:0]        master_err;
  logic [MASTERS*DATA_W-1:0] master_rdata;
  logic                      slave_req;
  logic [ADDR_W-1:0]         slave_addr;
  logic                      slave_cmd;
  logic [DATA_W-1:0]         slave_wdata;
  logic                      slave_ack;
  logic [DATA_W-1:0]         slave_rdata;
  logic [ID_W-1:0]           slave_master_id;

  modport mux (
    input  master_req, master_addr, master_cmd, master_wdata, slave_ack, slave_rdata,
    output master_ack, master_err, master_rdata,
    output slave_req, slave_addr, slave_cmd, slave_wdata, slave_master_id
  );

  modport master (
    output master_req, master_addr, master_cmd, master_wdata,
    input  master_ack, master_err, master_rdata
  );

  modport slave (
    input  slave_req, slave_addr, slave_cmd, slave_wdata, slave_master_id,
    output slave_ack, slave_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority picker: first set req bit searching upward from ptr, wrapping.
module rr_arbiter
  import mux_masters_pkg::*;
#(
  parameter int N = 4,
  localparam int W = width_of(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         any_req
);

  logic [W-1:0] idx;

  // Walk from lowest priority to highest so the closest request to ptr wins last.
  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % N);
      if (req[idx]) gnt_idx = idx;
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mux_masters_rr.sv
// N-master to 1-slave bus mux: round-robin grant held for a whole transaction,
// with an optional per-transaction timeout that acks the stalled master with an error.
module mux_masters_rr
  import mux_masters_pkg::*;
#(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mux_masters_rr_if.mux bus,
  output state_t        dbg_state
);

  localparam int ID_W  = width_of(MASTERS);
  localparam int CNT_W = width_of(TIMEOUT + 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(MASTERS - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  next_ptr;
  logic [CNT_W-1:0] tmo_cnt;
  logic             any_req;
  logic             tmo_hit;

  rr_arbiter #(.N(MASTERS)) u_arb (
    .req     (bus.master_req),
    .ptr     (rr_ptr),
    .gnt_idx (winner),
    .any_req (any_req)
  );

  assign next_ptr = (grant == LAST_ID) ? '0 : grant + ID_W'(1);
  // A same-cycle slave_ack always beats the timeout.
  assign tmo_hit  = (TIMEOUT != 0) && (state == BUSY) && !bus.slave_ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= winner;
            tmo_cnt <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.slave_ack || tmo_hit) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end else if (TIMEOUT != 0 && tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.slave_req    = 1'b0;
    bus.slave_addr   = '0;
    bus.slave_cmd    = CMD_READ;
    bus.slave_wdata  = '0;
    bus.master_ack   = '0;
    bus.master_err   = '0;
    bus.master_rdata = '0;
    if (state == BUSY) begin
      bus.slave_req         = 1'b1;
      bus.slave_addr        = bus.master_addr[int'(grant)*ADDR_W +: ADDR_W];
      bus.slave_cmd         = bus.master_cmd[grant];
      bus.slave_wdata       = bus.master_wdata[int'(grant)*DATA_W +: DATA_W];
      bus.master_ack[grant] = bus.slave_ack | tmo_hit;
      bus.master_err[grant] = tmo_hit;
      if (bus.slave_ack) bus.master_rdata[int'(grant)*DATA_W +: DATA_W] = bus.slave_rdata;
    end
  end

  // Held at the last grant through IDLE for trace purposes.
  assign bus.slave_master_id = grant;
  assign dbg_state           = state;

endmodule

// File: tb/tb_mux_masters_rr.sv
// Directed bench for mux_masters_rr with a transaction-level reference model checked every cycle.
module tb_mux_masters_rr;
  import mux_masters_pkg::*;

  localparam int MASTERS = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     checks   = 0;
  int     failures = 0;

  mux_masters_rr_if #(.MASTERS(MASTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mux_masters_rr #(
    .MASTERS(MASTERS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- slave responder ----------------
  int          ack_at     = 0;   // ack during this BUSY cycle (1-based); 0 = never
  bit          idle_pulse = 0;
  logic [31:0] rd_val     = 32'h0;
  int          busy_cyc   = 0;

  initial begin
    bus.slave_ack   = 1'b0;
    bus.slave_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      busy_cyc        = bus.slave_req ? busy_cyc + 1 : 0;
      bus.slave_ack   = idle_pulse || (ack_at != 0 && bus.slave_req && busy_cyc == ack_at);
      bus.slave_rdata = bus.slave_ack ? rd_val : $urandom();
    end
  end

  // ---------------- reference model ----------------
  bit m_busy  = 0;
  int m_owner = 0;
  int m_last  = MASTERS - 1;
  int m_id    = 0;
  int m_cnt   = 0;

  function automatic int pick(input logic [MASTERS-1:0] r, input int last);
    for (int k = 1; k <= MASTERS; k++) begin
      if (r[(last + k) % MASTERS]) return (last + k) % MASTERS;
    end
    return 0;
  endfunction

  logic [MASTERS-1:0]        e_ack, e_err;
  logic [MASTERS*DATA_W-1:0] e_rdata;
  logic                      e_req, e_cmd;
  logic [ADDR_W-1:0]         e_addr;
  logic [DATA_W-1:0]         e_wdata;
  int                        e_id;
  bit                        tmo;

  always @(negedge clk) begin
    e_ack = '0; e_err = '0; e_rdata = '0; e_req = 0; e_cmd = 0;
    e_addr = '0; e_wdata = '0; tmo = 0;
    if (rst) begin
      m_busy = 0; m_last = MASTERS - 1; m_id = 0; m_cnt = 0;
    end
    if (m_busy) begin
      e_req   = 1;
      e_addr  = bus.master_addr[m_owner*ADDR_W +: ADDR_W];
      e_cmd   = bus.master_cmd[m_owner];
      e_wdata = bus.master_wdata[m_owner*DATA_W +: DATA_W];
      e_id    = m_owner;
      tmo     = (TIMEOUT != 0) && (m_cnt == TIMEOUT) && !bus.slave_ack;
      e_ack[m_owner] = bus.slave_ack || tmo;
      e_err[m_owner] = tmo;
      if (bus.slave_ack) e_rdata[m_owner*DATA_W +: DATA_W] = bus.slave_rdata;
    end else begin
      e_id = m_id;
    end
    chk("cyc slave_req", bus.slave_req, e_req);
    chk("cyc slave_addr", bus.slave_addr, e_addr);
    chk("cyc slave_cmd", bus.slave_cmd, e_cmd);
    chk("cyc slave_wdata", bus.slave_wdata, e_wdata);
    chk("cyc slave_master_id", bus.slave_master_id, e_id);
    chk("cyc master_ack", bus.master_ack, e_ack);
    chk("cyc master_err", bus.master_err, e_err);
    chk("cyc master_rdata", bus.master_rdata, e_rdata);
    chk("cyc state", dbg_state, m_busy ? BUSY : IDLE);
    if (!rst) begin
      if (m_busy) begin
        if (bus.slave_ack || tmo) begin
          m_busy = 0; m_last = m_owner; m_id = m_owner;
        end else begin
          m_cnt++;
        end
      end else if (|bus.master_req) begin
        m_owner = pick(bus.master_req, m_last);
        m_busy  = 1; m_cnt = 1; m_id = m_owner;
      end
    end
  end

  // ---------------- grant / bubble monitor ----------------
  int grant_q[$];
  int gap_q[$];
  int idle_run  = 0;
  bit seen_busy = 0;
  bit prev_sreq = 0;

  always @(negedge clk) begin
    if (rst) begin
      grant_q.delete(); gap_q.delete(); seen_busy = 0; idle_run = 0;
    end else if (bus.slave_req && !prev_sreq) begin
      grant_q.push_back(int'(bus.slave_master_id));
      if (seen_busy) gap_q.push_back(idle_run);
      seen_busy = 1;
    end
    idle_run  = bus.slave_req ? 0 : idle_run + 1;
    prev_sreq = bus.slave_req;
  end

  // ---------------- driver tasks ----------------
  task automatic set_master(input int i, input logic req, input logic [31:0] addr,
                            input logic cmd, input logic [31:0] wdata);
    bus.master_addr[i*ADDR_W +: ADDR_W]  = addr;
    bus.master_cmd[i]                    = cmd;
    bus.master_wdata[i*DATA_W +: DATA_W] = wdata;
    bus.master_req[i]                    = req;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_drive();
    rst = 1'b1;
    bus.master_req = '0;
    ack_at = 0;
    next_drive();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input string name, output logic [MASTERS-1:0] ack,
                          output logic [MASTERS-1:0] err,
                          output logic [MASTERS*DATA_W-1:0] rdata, output int busy_n);
    busy_n = 0; ack = '0; err = '0; rdata = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.slave_req) busy_n++;
      if (bus.master_ack != '0) begin
        ack = bus.master_ack; err = bus.master_err; rdata = bus.master_rdata;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL %s: no master_ack within 40 cycles (got none, required one)", name);
  endtask

  // ---------------- directed tests ----------------
  logic [MASTERS-1:0]        a, e;
  logic [MASTERS*DATA_W-1:0] r, exp_r;
  int                        n;
  int                        exp_order[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst = 1'b1;
    bus.master_req = '0; bus.master_addr = '0; bus.master_cmd = '0; bus.master_wdata = '0;
    @(negedge clk);
    chk("reset slave_req", bus.slave_req, 0);
    chk("reset master_ack", bus.master_ack, 0);
    chk("reset slave_master_id", bus.slave_master_id, 0);
    next_drive();
    rst = 1'b0;

    // 1: single read from master 2, ack in the 4th BUSY cycle
    ack_at = 4; rd_val = 32'hA5A5A5A5;
    next_drive();
    set_master(2, 1, 32'h10, CMD_READ, 32'h0);
    @(negedge clk);
    chk("t1 no slave_req same cycle", bus.slave_req, 0);
    @(negedge clk);
    chk("t1 slave_req after 1clk", bus.slave_req, 1);
    chk("t1 slave_addr", bus.slave_addr, 32'h10);
    chk("t1 slave_master_id", bus.slave_master_id, 2);
    wait_ack("t1", a, e, r, n);
    exp_r = '0; exp_r[2*DATA_W +: DATA_W] = 32'hA5A5A5A5;
    chk("t1 ack latency", n, 3);
    chk("t1 ack mask", a, 4'b0100);
    chk("t1 err mask", e, 4'b0000);
    chk("t1 rdata lanes", r, exp_r);
    next_drive();
    bus.master_req = '0;
    @(negedge clk);
    chk("t1 idle after ack", bus.slave_req, 0);
    chk("t1 id held in idle", bus.slave_master_id, 2);

    // 2: all four masters request continuously
    do_reset();
    ack_at = 2;
    for (int i = 0; i < MASTERS; i++) set_master(i, 1, 32'h100 * (i + 1), i[0], 32'h1111 * (i + 1));
    for (int c = 0; c < 60 && grant_q.size() < 6; c++) @(negedge clk);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t2 grant %0d", k), (k < grant_q.size()) ? grant_q[k] : -1, exp_order[k]);
    for (int k = 0; k < 5; k++)
      chk($sformatf("t2 bubble %0d", k), (k < gap_q.size()) ? gap_q[k] : -1, 1);
    next_drive();
    bus.master_req = '0;
    repeat (4) @(negedge clk);

    // 3: write from master 1 with no slave_ack -> timeout after 8 BUSY cycles
    do_reset();
    set_master(1, 1, 32'h2000, CMD_WRITE, 32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk);
    chk("t3 slave_cmd", bus.slave_cmd, 1);
    chk("t3 slave_wdata", bus.slave_wdata, 32'hDEADBEEF);
    chk("t3 slave_master_id", bus.slave_master_id, 1);
    wait_ack("t3", a, e, r, n);
    chk("t3 busy cycles", n + 1, 8);
    chk("t3 ack mask", a, 4'b0010);
    chk("t3 err mask", e, 4'b0010);
    chk("t3 rdata zero", r, 0);
    next_drive();
    bus.master_req = 4'b0111;
    @(negedge clk);
    chk("t3 idle bubble", bus.slave_req, 0);
    ack_at = 2;
    @(negedge clk);
    chk("t3 next grant from ptr 2", bus.slave_master_id, 2);
    wait_ack("t3b", a, e, r, n);
    chk("t3b ack mask", a, 4'b0100);
    next_drive();
    bus.master_req = '0;

    // 4: ack arrives in the 8th BUSY cycle, same cycle as the timeout would fire
    do_reset();
    ack_at = 8; rd_val = 32'h12345678;
    set_master(3, 1, 32'h3000, CMD_READ, 32'h0);
    wait_ack("t4", a, e, r, n);
    exp_r = '0; exp_r[3*DATA_W +: DATA_W] = 32'h12345678;
    chk("t4 busy cycles", n, 8);
    chk("t4 ack mask", a, 4'b1000);
    chk("t4 err mask", e, 4'b0000);
    chk("t4 rdata lanes", r, exp_r);
    next_drive();
    bus.master_req = '0;

    // 5: reset in the 2nd BUSY cycle of a master 3 transaction
    do_reset();
    set_master(3, 1, 32'h3300, CMD_READ, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t5 busy for master 3", bus.slave_master_id, 3);
    next_drive();
    rst = 1'b1;
    set_master(0, 1, 32'h0400, CMD_WRITE, 32'hCAFE0000);
    #1;
    chk("t5 async slave_req drop", bus.slave_req, 0);
    chk("t5 async ack zero", bus.master_ack, 0);
    next_drive();
    rst = 1'b0;
    @(negedge clk);
    ack_at = 2;
    @(negedge clk);
    chk("t5 master 0 first", bus.slave_master_id, 0);
    wait_ack("t5a", a, e, r, n);
    chk("t5a ack mask", a, 4'b0001);
    next_drive();
    bus.master_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5 then master 3", bus.slave_master_id, 3);
    wait_ack("t5b", a, e, r, n);
    chk("t5b ack mask", a, 4'b1000);
    next_drive();
    bus.master_req = '0;

    // 6: stray slave_ack in IDLE, then master 0 drops req mid-BUSY
    do_reset();
    @(negedge clk);
    idle_pulse = 1;
    @(negedge clk);
    idle_pulse = 0;
    chk("t6 idle ack ignored", bus.master_ack, 0);
    chk("t6 idle no req", bus.slave_req, 0);
    @(negedge clk);
    chk("t6 still idle", dbg_state, IDLE);
    ack_at = 4; rd_val = 32'h0BADF00D;
    next_drive();
    set_master(0, 1, 32'h0500, CMD_READ, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t6 granted 0", bus.slave_master_id, 0);
    next_drive();
    bus.master_req[0] = 1'b0;
    wait_ack("t6", a, e, r, n);
    exp_r = '0; exp_r[0 +: DATA_W] = 32'h0BADF00D;
    chk("t6 grant held ack", a, 4'b0001);
    chk("t6 rdata lane 0", r, exp_r);
    chk("t6 ack in 4th busy", n, 3);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
